// File: rtl/luma16_pkg.sv
// Shared definitions for the luma 16x16 intra mode decision: mode codes, SAD widths, FSM states.
// No logic of its own; absdiff8 is the per-pixel cost used by the row SAD units.
// Imported by sad_row16 and mode_decision_luma16x16.
package luma16_pkg;

  localparam logic [1:0] MODE_V  = 2'd0;
  localparam logic [1:0] MODE_H  = 2'd1;
  localparam logic [1:0] MODE_DC = 2'd2;

  localparam int SAD_W    = 16;
  localparam int ROWSAD_W = 12;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  function automatic logic [7:0] absdiff8(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/sad_row16.sv
// Sum of absolute differences across one 16-pixel row (max 16*255 = 4080).
// Latency: purely combinational.
// Backpressure: none, no state.
module sad_row16
  import luma16_pkg::*;
(
  input  logic [15:0][7:0]      a,
  input  logic [15:0][7:0]      b,
  output logic [ROWSAD_W-1:0]   sad
);

  always_comb begin
    sad = '0;
    for (int i = 0; i < 16; i++) begin
      sad = sad + ROWSAD_W'(absdiff8(a[i], b[i]));
    end
  end

endmodule

// File: rtl/mode_decision_luma16x16.sv
// Accumulates V/H/DC SADs of a 16x16 luma MB over 16/ROWS_PER_CYCLE cycles, picks the cheapest mode (LUMA16_AVAIL_MASK_EN adds neighbour masks).
// Latency: start at edge E0 -> done high between E(N+1) and E(N+2), N = 16/ROWS_PER_CYCLE.
// Backpressure: none; start is only honoured in IDLE, inputs must be held stable until done.
module mode_decision_luma16x16
  import luma16_pkg::*;
#(
  parameter int ROWS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [255:0][7:0]     orig,
  input  logic [255:0][7:0]     vpred,
  input  logic [255:0][7:0]     hpred,
  input  logic [255:0][7:0]     dcpred,
`ifdef LUMA16_AVAIL_MASK_EN
  input  logic                  top_avail,
  input  logic                  left_avail,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            best_mode,
  output logic [SAD_W-1:0]      best_sad,
  output logic [SAD_W-1:0]      sad_v,
  output logic [SAD_W-1:0]      sad_h,
  output logic [SAD_W-1:0]      sad_dc
);

  state_t               state, state_nx;
  logic [4:0]           row;
  logic [SAD_W-1:0]     acc_v, acc_h, acc_dc;
  logic [SAD_W-1:0]     grp_v, grp_h, grp_dc;
  logic [ROWSAD_W-1:0]  rs_v  [ROWS_PER_CYCLE];
  logic [ROWSAD_W-1:0]  rs_h  [ROWS_PER_CYCLE];
  logic [ROWSAD_W-1:0]  rs_dc [ROWS_PER_CYCLE];
  logic                 elig_v, elig_h;
  logic [1:0]           sel_mode;
  logic [SAD_W-1:0]     sel_sad;

  // Row 16 is the extra select cycle; the wrapped index it produces is never accumulated.
  for (genvar g = 0; g < ROWS_PER_CYCLE; g++) begin : g_row
    logic [3:0] ridx;
    logic [7:0] base;
    assign ridx = row[3:0] + 4'(g);
    assign base = {ridx, 4'b0000};
    sad_row16 u_sad_v  (.a(orig[base +: 16]), .b(vpred[base +: 16]),  .sad(rs_v[g]));
    sad_row16 u_sad_h  (.a(orig[base +: 16]), .b(hpred[base +: 16]),  .sad(rs_h[g]));
    sad_row16 u_sad_dc (.a(orig[base +: 16]), .b(dcpred[base +: 16]), .sad(rs_dc[g]));
  end

  always_comb begin
    grp_v  = '0;
    grp_h  = '0;
    grp_dc = '0;
    for (int g = 0; g < ROWS_PER_CYCLE; g++) begin
      grp_v  = grp_v  + SAD_W'(rs_v[g]);
      grp_h  = grp_h  + SAD_W'(rs_h[g]);
      grp_dc = grp_dc + SAD_W'(rs_dc[g]);
    end
  end

`ifdef LUMA16_AVAIL_MASK_EN
  logic top_q, left_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      top_q  <= 1'b0;
      left_q <= 1'b0;
    end else if (state == IDLE && start) begin
      top_q  <= top_avail;
      left_q <= left_avail;
    end
  end
  assign elig_v = top_q;
  assign elig_h = left_q;
`else
  assign elig_v = 1'b1;
  assign elig_h = 1'b1;
`endif

  // Start from DC (always eligible) and let lower modes take over on <= so ties favour them.
  always_comb begin
    sel_mode = MODE_DC;
    sel_sad  = acc_dc;
    if (elig_h && acc_h <= sel_sad) begin
      sel_mode = MODE_H;
      sel_sad  = acc_h;
    end
    if (elig_v && acc_v <= sel_sad) begin
      sel_mode = MODE_V;
      sel_sad  = acc_v;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = ACCUM;
      ACCUM:   if (row == 5'd16) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row       <= '0;
      acc_v     <= '0;
      acc_h     <= '0;
      acc_dc    <= '0;
      best_mode <= '0;
      best_sad  <= '0;
      sad_v     <= '0;
      sad_h     <= '0;
      sad_dc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            row    <= '0;
            acc_v  <= '0;
            acc_h  <= '0;
            acc_dc <= '0;
          end
        end
        ACCUM: begin
          if (row == 5'd16) begin
            row       <= '0;
            sad_v     <= acc_v;
            sad_h     <= acc_h;
            sad_dc    <= acc_dc;
            best_mode <= sel_mode;
            best_sad  <= sel_sad;
          end else begin
            row    <= row + 5'(ROWS_PER_CYCLE);
            acc_v  <= acc_v + grp_v;
            acc_h  <= acc_h + grp_h;
            acc_dc <= acc_dc + grp_dc;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_mode_decision_luma16x16.sv
// Randomised and directed checks of mode_decision_luma16x16 (1 and 4 rows/cycle) against a whole-block SAD model.
module tb_mode_decision_luma16x16;

  logic clk = 1'b0;
  logic reset, start, start4;
  logic [255:0][7:0] orig, vpred, hpred, dcpred;
  logic top_avail, left_avail;

  logic        busy, done, busy4, done4;
  logic [1:0]  best_mode, best_mode4;
  logic [15:0] best_sad, sad_v, sad_h, sad_dc;
  logic [15:0] best_sad4, sad_v4, sad_h4, sad_dc4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mode_decision_luma16x16 #(.ROWS_PER_CYCLE(1)) u_dut (
    .clk(clk), .reset(reset), .start(start),
    .orig(orig), .vpred(vpred), .hpred(hpred), .dcpred(dcpred),
`ifdef LUMA16_AVAIL_MASK_EN
    .top_avail(top_avail), .left_avail(left_avail),
`endif
    .busy(busy), .done(done), .best_mode(best_mode), .best_sad(best_sad),
    .sad_v(sad_v), .sad_h(sad_h), .sad_dc(sad_dc)
  );

  mode_decision_luma16x16 #(.ROWS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4),
    .orig(orig), .vpred(vpred), .hpred(hpred), .dcpred(dcpred),
`ifdef LUMA16_AVAIL_MASK_EN
    .top_avail(top_avail), .left_avail(left_avail),
`endif
    .busy(busy4), .done(done4), .best_mode(best_mode4), .best_sad(best_sad4),
    .sad_v(sad_v4), .sad_h(sad_h4), .sad_dc(sad_dc4)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int unsigned ref_sad(input logic [255:0][7:0] a, input logic [255:0][7:0] b);
    int s = 0;
    for (int i = 0; i < 256; i++) begin
      int d = int'(a[i]) - int'(b[i]);
      s += (d < 0) ? -d : d;
    end
    return s;
  endfunction

  // Runs one decision; restart_at > 0 re-pulses start on that ACCUM cycle.
  task automatic run_op(input string tag, input bit use4, input int restart_at);
    int unsigned sads[3];
    bit          elig[3];
    int          bm, n_exp, got_cyc;
    sads[0] = ref_sad(orig, vpred);
    sads[1] = ref_sad(orig, hpred);
    sads[2] = ref_sad(orig, dcpred);
`ifdef LUMA16_AVAIL_MASK_EN
    elig[0] = top_avail;
    elig[1] = left_avail;
`else
    elig[0] = 1'b1;
    elig[1] = 1'b1;
`endif
    elig[2] = 1'b1;
    bm = -1;
    for (int m = 0; m < 3; m++)
      if (elig[m] && (bm < 0 || sads[m] < sads[bm])) bm = m;
    n_exp = use4 ? 5 : 17;

    @(negedge clk);
    if (use4) start4 = 1'b1; else start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    start4 = 1'b0;
    check({tag, "_busy"}, use4 ? busy4 : busy, 1);
    got_cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c == restart_at) begin
        if (use4) start4 = 1'b1; else start = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      start4 = 1'b0;
      if ((use4 ? done4 : done) == 1'b1) begin
        got_cyc = c;
        break;
      end
    end
    check({tag, "_latency"}, got_cyc, n_exp);
    if (got_cyc == 0) return;
    check({tag, "_sad_v"},  use4 ? sad_v4  : sad_v,  sads[0]);
    check({tag, "_sad_h"},  use4 ? sad_h4  : sad_h,  sads[1]);
    check({tag, "_sad_dc"}, use4 ? sad_dc4 : sad_dc, sads[2]);
    check({tag, "_mode"},   use4 ? best_mode4 : best_mode, bm);
    check({tag, "_best"},   use4 ? best_sad4  : best_sad,  sads[bm]);
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, use4 ? done4 : done, 0);
    check({tag, "_hold"},  use4 ? best_sad4 : best_sad, sads[bm]);
  endtask

  task automatic rand_arrays(input int kind);
    for (int i = 0; i < 256; i++) begin
      orig[i] = 8'($urandom_range(0, 255));
      if (kind == 0) begin
        vpred[i]  = 8'($urandom_range(0, 255));
        hpred[i]  = 8'($urandom_range(0, 255));
        dcpred[i] = 8'($urandom_range(0, 255));
      end else begin
        // near-equal predictions make ties between modes likely
        vpred[i]  = (orig[i] > 0 && $urandom_range(0, 7) == 0) ? orig[i] - 8'd1 : orig[i];
        hpred[i]  = (orig[i] > 0 && $urandom_range(0, 7) == 0) ? orig[i] - 8'd1 : orig[i];
        dcpred[i] = (orig[i] > 0 && $urandom_range(0, 7) == 0) ? orig[i] - 8'd1 : orig[i];
      end
    end
  endtask

  initial begin
    int ndone;
    reset = 1'b1;
    start = 1'b0;
    start4 = 1'b0;
    top_avail = 1'b1;
    left_avail = 1'b1;
    orig = '0; vpred = '0; hpred = '0; dcpred = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mode", best_mode, 0);
    check("rst_best", best_sad, 0);
    check("rst_sads", sad_v | sad_h | sad_dc, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 256; i++) begin
      orig[i] = 8'd100; vpred[i] = 8'd100; hpred[i] = 8'd90; dcpred[i] = 8'd110;
    end
    run_op("flat", 1'b0, 0);

    for (int i = 0; i < 256; i++) begin
      orig[i] = 8'($urandom_range(0, 254));
      vpred[i] = orig[i] + 8'd1; hpred[i] = orig[i]; dcpred[i] = orig[i];
    end
    run_op("tie_hdc", 1'b0, 0);

    for (int i = 0; i < 256; i++) begin
      orig[i] = 8'd255; vpred[i] = 8'd0; hpred[i] = 8'd0; dcpred[i] = 8'd0;
    end
    run_op("max1", 1'b0, 0);
    run_op("max4", 1'b1, 0);

    rand_arrays(0);
    run_op("restart", 1'b0, 5);
    ndone = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("restart_no_extra_done", ndone, 0);

    for (int k = 0; k < 10; k++) begin
`ifdef LUMA16_AVAIL_MASK_EN
      top_avail = 1'($urandom_range(0, 1));
      left_avail = 1'($urandom_range(0, 1));
`endif
      rand_arrays(k % 2);
      run_op($sformatf("rnd%0d", k), 1'(k % 3 == 2), 0);
    end

`ifdef LUMA16_AVAIL_MASK_EN
    top_avail = 1'b0;
    left_avail = 1'b1;
    for (int i = 0; i < 256; i++) begin
      orig[i] = 8'd100; vpred[i] = 8'd100;
      hpred[i] = (i < 64) ? 8'd108 : 8'd100;
      dcpred[i] = 8'd101;
    end
    run_op("mask_top", 1'b0, 0);
    top_avail = 1'b1;
`endif

    // mid-operation reset after a nonzero result is held
    for (int i = 0; i < 256; i++) begin
      orig[i] = 8'd200; vpred[i] = 8'd10; hpred[i] = 8'd20; dcpred[i] = 8'd30;
    end
    run_op("pre_reset", 1'b0, 0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_sad_v", sad_v, 0);
    check("midrst_sad_h", sad_h, 0);
    check("midrst_sad_dc", sad_dc, 0);
    check("midrst_best", best_sad, 0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("midrst_no_done", ndone, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
